// File: rtl/cache_ctrl_pkg.sv
// Shared types for the L1 cache controller: FSM states, way index, way count.
package cache_ctrl_pkg;

  localparam int unsigned NUM_WAYS = 2;

  typedef logic way_t;

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the cache performance counters.
module sat_counter #(
  parameter int unsigned width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [width-1:0] count
);

  logic [width-1:0] count_q;

  // Increment on request, hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + width'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/l1_cache_control.sv
// Two-way L1 cache control FSM: hit handling, dirty-victim writeback,
// line allocation from physical memory, and hit/miss performance counters.
module l1_cache_control
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned s_index   = 3,
  parameter int unsigned cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,
  input  logic [NUM_WAYS-1:0]  hit,
  input  logic [NUM_WAYS-1:0]  dirty,
  input  logic                 lru_way,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp,
  output logic [NUM_WAYS-1:0]  way_load,
  output logic [NUM_WAYS-1:0]  dirty_load,
  output logic                 dirty_in,
  output logic                 lru_load,
  output logic                 lru_in,
  output logic                 addr_sel,
  output logic [cnt_width-1:0] hit_count,
  output logic [cnt_width-1:0] miss_count
);

  // The set index only sizes the datapath arrays; reject a degenerate value here.
  if (s_index == 0) begin : g_bad_s_index
    $error("l1_cache_control: s_index must be at least 1");
  end

  state_t state_q, state_d;
  way_t   victim_q, victim_d;
  way_t   hit_way;
  logic   req;
  logic   hit_inc;
  logic   miss_inc;

  assign req     = mem_read | mem_write;
  // Way 0 wins if both ways report a match.
  assign hit_way = hit[0] ? 1'b0 : 1'b1;

  // State and victim registers; reset drops any in-flight miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CHECK;
      victim_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  // Next-state and output decode; every output is forced low while in reset.
  always_comb begin
    state_d    = state_q;
    victim_d   = victim_q;
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    way_load   = '0;
    dirty_load = '0;
    dirty_in   = 1'b0;
    lru_load   = 1'b0;
    lru_in     = 1'b0;
    addr_sel   = 1'b0;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    if (!rst) begin
      unique case (state_q)
        CHECK: begin
          if (req) begin
            if (|hit) begin
              mem_resp = 1'b1;
              lru_load = 1'b1;
              lru_in   = ~hit_way;
              hit_inc  = 1'b1;
              // A write (including read+write together) updates data and marks dirty.
              if (mem_write) begin
                way_load[hit_way]   = 1'b1;
                dirty_load[hit_way] = 1'b1;
                dirty_in            = 1'b1;
              end
            end else begin
              victim_d = lru_way;
              miss_inc = 1'b1;
              state_d  = dirty[lru_way] ? WRITEBACK : ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          pmem_write = 1'b1;
          addr_sel   = 1'b1;
          if (pmem_resp) begin
            state_d = ALLOCATE;
          end
        end
        ALLOCATE: begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            // Fill the latched victim; the fresh line is clean.
            way_load[victim_q]   = 1'b1;
            dirty_load[victim_q] = 1'b1;
            dirty_in             = 1'b0;
            state_d              = CHECK;
          end
        end
        default: begin
          state_d = CHECK;
        end
      endcase
    end
  end

  sat_counter #(
    .width (cnt_width)
  ) u_hit_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(
    .width (cnt_width)
  ) u_miss_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_count)
  );

endmodule

// File: tb/tb_l1_cache_control.sv
// Directed bench for l1_cache_control: hits, misses, writeback, reset abort,
// and counter saturation on a narrow-counter instance.
module tb_l1_cache_control;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, lru_way, pmem_resp;
  logic [1:0]  hit, dirty;

  logic        mem_resp, pmem_read, pmem_write, dirty_in, lru_load, lru_in, addr_sel;
  logic [1:0]  way_load, dirty_load;
  logic [15:0] hit_count, miss_count;

  logic        n_mem_resp, n_pmem_read, n_pmem_write, n_dirty_in, n_lru_load, n_lru_in;
  logic        n_addr_sel;
  logic [1:0]  n_way_load, n_dirty_load;
  logic [3:0]  n_hit_count, n_miss_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  l1_cache_control #(
    .s_index   (3),
    .cnt_width (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_resp   (mem_resp),
    .hit        (hit),
    .dirty      (dirty),
    .lru_way    (lru_way),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_resp  (pmem_resp),
    .way_load   (way_load),
    .dirty_load (dirty_load),
    .dirty_in   (dirty_in),
    .lru_load   (lru_load),
    .lru_in     (lru_in),
    .addr_sel   (addr_sel),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  l1_cache_control #(
    .s_index   (3),
    .cnt_width (4)
  ) dut4 (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_resp   (n_mem_resp),
    .hit        (hit),
    .dirty      (dirty),
    .lru_way    (lru_way),
    .pmem_read  (n_pmem_read),
    .pmem_write (n_pmem_write),
    .pmem_resp  (pmem_resp),
    .way_load   (n_way_load),
    .dirty_load (n_dirty_load),
    .dirty_in   (n_dirty_in),
    .lru_load   (n_lru_load),
    .lru_in     (n_lru_in),
    .addr_sel   (n_addr_sel),
    .hit_count  (n_hit_count),
    .miss_count (n_miss_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b1; mem_write = 1'b0; hit = 2'b01; dirty = 2'b00;
    lru_way = 1'b0; pmem_resp = 1'b0;
    tick();
    tick();
    #1;
    // Reset cycle: request with a hit is ignored, counters cleared.
    check("rst_mem_resp", 32'(mem_resp), 32'd0);
    check("rst_lru_load", 32'(lru_load), 32'd0);
    check("rst_hit_count", 32'(hit_count), 32'd0);
    check("rst_miss_count", 32'(miss_count), 32'd0);

    // Read hit way 0.
    rst = 1'b0; mem_read = 1'b1; hit = 2'b01;
    #1;
    check("rd_hit_resp", 32'(mem_resp), 32'd1);
    check("rd_hit_lru_load", 32'(lru_load), 32'd1);
    check("rd_hit_lru_in", 32'(lru_in), 32'd1);
    check("rd_hit_way_load", 32'(way_load), 32'd0);
    check("rd_hit_dirty_load", 32'(dirty_load), 32'd0);
    tick();
    check("rd_hit_count", 32'(hit_count), 32'd1);

    // Write hit way 1.
    mem_read = 1'b0; mem_write = 1'b1; hit = 2'b10;
    #1;
    check("wr_hit_resp", 32'(mem_resp), 32'd1);
    check("wr_hit_dirty_load", 32'(dirty_load), 32'b10);
    check("wr_hit_dirty_in", 32'(dirty_in), 32'd1);
    check("wr_hit_way_load", 32'(way_load), 32'b10);
    check("wr_hit_lru_in", 32'(lru_in), 32'd0);
    tick();

    // Read+write with illegal double hit: write to way 0.
    mem_read = 1'b1; mem_write = 1'b1; hit = 2'b11;
    #1;
    check("rw_hit11_way_load", 32'(way_load), 32'b01);
    check("rw_hit11_dirty_load", 32'(dirty_load), 32'b01);
    check("rw_hit11_lru_in", 32'(lru_in), 32'd1);
    tick();
    check("hit_count_3", 32'(hit_count), 32'd3);

    // Clean read miss, lru_way 0, pmem answers in the 3rd ALLOCATE cycle.
    mem_read = 1'b1; mem_write = 1'b0; hit = 2'b00; lru_way = 1'b0; dirty = 2'b00;
    #1;
    check("miss_no_resp", 32'(mem_resp), 32'd0);
    check("miss_check_pmem_read", 32'(pmem_read), 32'd0);
    tick();
    check("miss_count_1", 32'(miss_count), 32'd1);
    for (int i = 0; i < 2; i++) begin
      check("alloc_pmem_read", 32'(pmem_read), 32'd1);
      check("alloc_addr_sel", 32'(addr_sel), 32'd0);
      check("alloc_wait_way_load", 32'(way_load), 32'd0);
      tick();
    end
    pmem_resp = 1'b1;
    #1;
    check("alloc_resp_pmem_read", 32'(pmem_read), 32'd1);
    check("alloc_fill_way_load", 32'(way_load), 32'b01);
    check("alloc_fill_dirty_load", 32'(dirty_load), 32'b01);
    check("alloc_fill_dirty_in", 32'(dirty_in), 32'd0);
    tick();
    pmem_resp = 1'b0; hit = 2'b01;
    #1;
    check("retry_hit_resp", 32'(mem_resp), 32'd1);
    check("retry_pmem_read", 32'(pmem_read), 32'd0);
    tick();
    check("hit_count_4", 32'(hit_count), 32'd4);

    // Dirty read miss on way 1; lru_way toggles during the miss.
    hit = 2'b00; lru_way = 1'b1; dirty = 2'b10;
    tick();
    check("miss_count_2", 32'(miss_count), 32'd2);
    lru_way = 1'b0;
    #1;
    check("wb_pmem_write", 32'(pmem_write), 32'd1);
    check("wb_addr_sel", 32'(addr_sel), 32'd1);
    check("wb_pmem_read", 32'(pmem_read), 32'd0);
    tick();
    pmem_resp = 1'b1;
    #1;
    check("wb_resp_pmem_write", 32'(pmem_write), 32'd1);
    check("wb_resp_way_load", 32'(way_load), 32'd0);
    tick();
    pmem_resp = 1'b0;
    #1;
    check("wb_alloc_pmem_read", 32'(pmem_read), 32'd1);
    check("wb_alloc_pmem_write", 32'(pmem_write), 32'd0);
    check("wb_alloc_addr_sel", 32'(addr_sel), 32'd0);
    tick();
    pmem_resp = 1'b1;
    #1;
    check("wb_fill_victim_way1", 32'(way_load), 32'b10);
    check("wb_fill_dirty_load", 32'(dirty_load), 32'b10);
    tick();
    pmem_resp = 1'b0; hit = 2'b10; dirty = 2'b00;
    #1;
    check("wb_retry_resp", 32'(mem_resp), 32'd1);
    tick();

    // Request dropped mid-miss: fill completes, no response afterwards.
    hit = 2'b00; lru_way = 1'b0;
    tick();
    mem_read = 1'b0; pmem_resp = 1'b1;
    #1;
    check("drop_fill_way_load", 32'(way_load), 32'b01);
    tick();
    pmem_resp = 1'b0;
    #1;
    check("drop_no_resp", 32'(mem_resp), 32'd0);
    check("drop_idle_pmem_read", 32'(pmem_read), 32'd0);
    check("miss_count_3", 32'(miss_count), 32'd3);
    check("hit_count_5", 32'(hit_count), 32'd5);

    // Reset in the 2nd ALLOCATE cycle aborts the fill.
    mem_read = 1'b1; hit = 2'b00; lru_way = 1'b1; dirty = 2'b00;
    tick();
    check("abort_alloc_pmem_read", 32'(pmem_read), 32'd1);
    tick();
    rst = 1'b1; pmem_resp = 1'b1;
    #1;
    check("abort_rst_way_load", 32'(way_load), 32'd0);
    check("abort_rst_pmem_read", 32'(pmem_read), 32'd0);
    tick();
    rst = 1'b0; pmem_resp = 1'b0; mem_read = 1'b0;
    #1;
    check("abort_after_pmem_read", 32'(pmem_read), 32'd0);
    check("abort_after_way_load", 32'(way_load), 32'd0);
    check("abort_hit_count", 32'(hit_count), 32'd0);
    check("abort_miss_count", 32'(miss_count), 32'd0);

    // 2^4 + 5 hits: narrow counter saturates, wide one keeps counting.
    mem_read = 1'b1; hit = 2'b01;
    for (int i = 0; i < 21; i++) begin
      tick();
    end
    mem_read = 1'b0;
    #1;
    check("sat_hit_count4", 32'(n_hit_count), 32'hF);
    check("sat_hit_count16", 32'(hit_count), 32'd21);
    check("sat_miss_count4", 32'(n_miss_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
